// File: rtl/data_padder_if.sv
// Handshake bundle between the byte source, data_padder and the xor_up stage.
// master = byte source / block consumer side, slave = data_padder.
interface data_padder_if;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_last_i;
  logic        empty_msg_i;
  logic        byte_ready_o;
  logic [63:0] block_o;
  logic        block_valid_o;
  logic        block_last_o;
  logic        block_ready_i;

  modport master (
    output byte_i, byte_valid_i, byte_last_i, empty_msg_i, block_ready_i,
    input  byte_ready_o, block_o, block_valid_o, block_last_o
  );

  modport slave (
    input  byte_i, byte_valid_i, byte_last_i, empty_msg_i, block_ready_i,
    output byte_ready_o, block_o, block_valid_o, block_last_o
  );
endinterface

// File: rtl/data_padder.sv
// Packs a byte stream into 64-bit blocks with Ascon 10* padding for xor_up.
// Optional macro DATA_PADDER_CNT_EN adds the block_cnt_o per-message block counter.
module data_padder #(
  parameter logic [7:0] PAD_BYTE = 8'h80
`ifdef DATA_PADDER_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic               clock_i,
  input  logic               reset_i,
  data_padder_if.slave       bus
`ifdef DATA_PADDER_CNT_EN
  , output logic [CNT_W-1:0] block_cnt_o
`endif
);

  typedef enum logic [1:0] {COLLECT, FULL_OUT, PAD_ONLY, LAST_OUT} state_t;

  localparam logic [63:0] PAD_BLOCK = {PAD_BYTE, 56'h0};

  state_t      state, state_n;
  logic [2:0]  k, k_n;
  logic [63:0] shreg, shreg_n;
  logic        pad_pend, pad_pend_n;

  // Byte k lands in [63-8k -: 8], so the first byte of a block is the MSB.
  function automatic logic [63:0] put_byte(input logic [63:0] blk,
                                           input logic [2:0]  pos,
                                           input logic [7:0]  b);
    logic [63:0] r;
    r = blk;
    r[8*(7-int'(pos)) +: 8] = b;
    return r;
  endfunction

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state    <= COLLECT;
      k        <= 3'd0;
      shreg    <= 64'h0;
      pad_pend <= 1'b0;
    end else begin
      state    <= state_n;
      k        <= k_n;
      shreg    <= shreg_n;
      pad_pend <= pad_pend_n;
    end
  end

  always_comb begin
    state_n    = state;
    k_n        = k;
    shreg_n    = shreg;
    pad_pend_n = pad_pend;
    case (state)
      COLLECT: begin
        // A real byte always takes priority over the empty-message strobe.
        if (bus.byte_valid_i) begin
          shreg_n = put_byte(shreg, k, bus.byte_i);
          if (bus.byte_last_i) begin
            if (k == 3'd7) begin
              state_n    = FULL_OUT;
              pad_pend_n = 1'b1;
            end else begin
              shreg_n = put_byte(shreg_n, k + 3'd1, PAD_BYTE);
              state_n = LAST_OUT;
            end
          end else if (k == 3'd7) begin
            state_n = FULL_OUT;
          end else begin
            k_n = k + 3'd1;
          end
        end else if (bus.empty_msg_i) begin
          shreg_n = PAD_BLOCK;
          state_n = LAST_OUT;
        end
      end
      FULL_OUT: begin
        if (bus.block_ready_i) begin
          k_n = 3'd0;
          if (pad_pend) begin
            shreg_n = PAD_BLOCK;
            state_n = PAD_ONLY;
          end else begin
            shreg_n = 64'h0;
            state_n = COLLECT;
          end
        end
      end
      PAD_ONLY, LAST_OUT: begin
        if (bus.block_ready_i) begin
          pad_pend_n = 1'b0;
          k_n        = 3'd0;
          shreg_n    = 64'h0;
          state_n    = COLLECT;
        end
      end
      default: begin
        state_n = COLLECT;
      end
    endcase
  end

  assign bus.byte_ready_o  = (state == COLLECT);
  assign bus.block_valid_o = (state != COLLECT);
  assign bus.block_last_o  = (state == PAD_ONLY) || (state == LAST_OUT);
  assign bus.block_o       = shreg;

`ifdef DATA_PADDER_CNT_EN
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             blk_accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign blk_accept = bus.block_valid_o & bus.block_ready_i;

  // The count including the last block is visible for one cycle, then clears.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt     <= '0;
      cnt_clr <= 1'b0;
    end else if (blk_accept) begin
      cnt     <= sat_inc(cnt);
      cnt_clr <= bus.block_last_o;
    end else if (cnt_clr) begin
      cnt     <= '0;
      cnt_clr <= 1'b0;
    end
  end

  assign block_cnt_o = cnt;
`endif

endmodule
